// File: rtl/vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_sequencer
// Description : LFSR-driven stimulus/checker for the (a+b) < (c-d) datapath;
//               holds each vector HOLD cycles, samples out, tallies mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_sequencer #(
    parameter  int          NUM_VEC = 16,
    parameter  int          HOLD    = 2,
    parameter  logic [15:0] SEED    = 16'hACE1,
    localparam int          IW      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
    localparam int          CW      = $clog2(NUM_VEC + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          out,
    output logic [3:0]    a,
    output logic [3:0]    b,
    output logic [3:0]    c,
    output logic [3:0]    d,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_count,
    output logic [IW-1:0] vec_idx,
    output logic          fail_valid,
    output logic [IW-1:0] fail_idx
);

    localparam int          HW         = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [15:0] c_SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] c_POLY     = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [15:0]     ops_q, ops_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [IW-1:0]   vec_idx_q, vec_idx_d;
    logic [CW-1:0]   err_q, err_d;
    logic            fail_valid_q, fail_valid_d;
    logic [IW-1:0]   fail_idx_q, fail_idx_d;

    logic [15:0]     w_lfsr_adv;
    logic [3:0]      w_sum;
    logic [3:0]      w_diff;
    logic            w_exp;

    assign w_lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? c_POLY : 16'h0000);

    // Golden model works on the registered operands, i.e. exactly what the datapath sees.
    assign w_sum  = ops_q[15:12] + ops_q[11:8];
    assign w_diff = ops_q[7:4]   - ops_q[3:0];
    assign w_exp  = (w_sum < w_diff);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        hold_d       = hold_q;
        vec_idx_d    = vec_idx_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_idx_d   = fail_idx_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_DRIVE;
                    lfsr_d       = c_SEED_EFF;
                    hold_d       = '0;
                    vec_idx_d    = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_idx_d   = '0;
                end
            end
            S_DRIVE: begin
                if (hold_q == HW'(HOLD - 1)) begin
                    state_d = S_CHECK;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_CHECK: begin
                if (out != w_exp) begin
                    err_d = err_q + CW'(1);
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_idx_d   = vec_idx_q;
                    end
                end
                if (vec_idx_q == IW'(NUM_VEC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_DRIVE;
                    lfsr_d    = w_lfsr_adv;
                    vec_idx_d = vec_idx_q + IW'(1);
                    hold_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Operands follow the next LFSR value so they change on the same edge as the state.
        ops_d = (state_d == S_DRIVE || state_d == S_CHECK) ? lfsr_d : 16'h0000;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= '0;
            ops_q        <= '0;
            hold_q       <= '0;
            vec_idx_q    <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            ops_q        <= ops_d;
            hold_q       <= hold_d;
            vec_idx_q    <= vec_idx_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_idx_q   <= fail_idx_d;
        end
    end

    assign a          = ops_q[15:12];
    assign b          = ops_q[11:8];
    assign c          = ops_q[7:4];
    assign d          = ops_q[3:0];
    assign busy       = (state_q == S_DRIVE) || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign vec_idx    = vec_idx_q;
    assign fail_valid = fail_valid_q;
    assign fail_idx   = fail_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_sequencer
// Description : Scoreboard bench for vector_sequencer with a behavioural
//               compare-datapath model in front of each instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_sequencer;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] ops;
    } vexp_t;

    typedef struct packed {
        logic [7:0] cycles;
        logic [2:0] err;
        logic       fv;
        logic [1:0] fi;
        logic       pass;
    } run_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic out0, out1;
    int   mode0 = 0, mode1 = 0;

    logic [3:0] a0, b0, c0, d0, a1, b1, c1, d1;
    logic       busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
    logic [2:0] err0;
    logic [1:0] idx0, fidx0;
    logic [0:0] err1, idx1, fidx1;

    int n_cmp = 0;
    int n_bad = 0;

    vexp_t op0_q[$], op1_q[$];
    run_t  run0_q[$], run1_q[$];

    // Hand-derived vectors for the default seed; every one has exp = 1.
    logic [15:0] vec_tbl [4] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};

    always #5 clock = ~clock;

    vector_sequencer #(.NUM_VEC(4), .HOLD(2), .SEED(16'hACE1)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .out(out0),
        .a(a0), .b(b0), .c(c0), .d(d0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .vec_idx(idx0), .fail_valid(fv0), .fail_idx(fidx0)
    );

    vector_sequencer #(.NUM_VEC(1), .HOLD(2), .SEED(16'hF101)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .out(out1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .vec_idx(idx1), .fail_valid(fv1), .fail_idx(fidx1)
    );

    logic [3:0] s0, df0, s1, df1;
    logic       ideal0, ideal1;
    always_comb begin
        s0     = a0 + b0;
        df0    = c0 - d0;
        ideal0 = (s0 < df0);
        s1     = a1 + b1;
        df1    = c1 - d1;
        ideal1 = (s1 < df1);
        case (mode0)
            0:       out0 = ideal0;
            1:       out0 = 1'b0;
            2:       out0 = ideal0 ^ ({a0, b0, c0, d0} == 16'h7138);
            default: out0 = ideal0 ^ (({a0, b0, c0, d0} == 16'hE270) || ({a0, b0, c0, d0} == 16'h389C));
        endcase
        out1 = (mode1 == 0) ? ideal1 : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for dut0
    logic       pb0 = 1'b0, pd0 = 1'b0;
    logic [1:0] pidx0 = '0;
    int         bcnt0 = 0;
    always @(negedge clock) begin
        vexp_t v;
        run_t  r;
        if (reset) begin
            pb0 = 1'b0; pd0 = 1'b0; bcnt0 = 0;
        end else begin
            if (busy0) begin
                bcnt0++;
                if (!pb0 || idx0 != pidx0) begin
                    if (op0_q.size() == 0) chk("dut0_unexpected_vector", {30'd0, idx0}, 32'hFFFF_FFFF);
                    else begin
                        v = op0_q.pop_front();
                        chk("dut0_vec_idx", idx0, v.idx);
                        chk("dut0_operands", {a0, b0, c0, d0}, v.ops);
                    end
                end
            end
            if (done0 && !pd0) begin
                if (run0_q.size() == 0) chk("dut0_unexpected_done", done0, 1'b0);
                else begin
                    r = run0_q.pop_front();
                    chk("dut0_busy_cycles", bcnt0, r.cycles);
                    chk("dut0_busy_at_done", busy0, 1'b0);
                    chk("dut0_err_count", err0, r.err);
                    chk("dut0_fail_valid", fv0, r.fv);
                    chk("dut0_fail_idx", fidx0, r.fi);
                    chk("dut0_pass", pass0, r.pass);
                    chk("dut0_ops_zero_in_done", {a0, b0, c0, d0}, 16'h0);
                end
                bcnt0 = 0;
            end
            pb0 = busy0; pd0 = done0; pidx0 = idx0;
        end
    end

    // Monitor for dut1
    logic pb1 = 1'b0, pd1 = 1'b0;
    int   bcnt1 = 0;
    always @(negedge clock) begin
        vexp_t v;
        run_t  r;
        if (reset) begin
            pb1 = 1'b0; pd1 = 1'b0; bcnt1 = 0;
        end else begin
            if (busy1) begin
                bcnt1++;
                if (!pb1) begin
                    if (op1_q.size() == 0) chk("dut1_unexpected_vector", {31'd0, idx1}, 32'hFFFF_FFFF);
                    else begin
                        v = op1_q.pop_front();
                        chk("dut1_vec_idx", idx1, v.idx);
                        chk("dut1_operands", {a1, b1, c1, d1}, v.ops);
                    end
                end
            end
            if (done1 && !pd1) begin
                if (run1_q.size() == 0) chk("dut1_unexpected_done", done1, 1'b0);
                else begin
                    r = run1_q.pop_front();
                    chk("dut1_busy_cycles", bcnt1, r.cycles);
                    chk("dut1_err_count", err1, r.err);
                    chk("dut1_fail_valid", fv1, r.fv);
                    chk("dut1_fail_idx", fidx1, r.fi);
                    chk("dut1_pass", pass1, r.pass);
                end
                bcnt1 = 0;
            end
            pb1 = busy1; pd1 = done1;
        end
    end

    task automatic wait_done(input int which);
        logic seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if ((which == 0) ? done0 : done1) begin
                seen = 1'b1;
                break;
            end
        end
        chk((which == 0) ? "dut0_done_timeout" : "dut1_done_timeout", seen, 1'b1);
        @(posedge clock);
    endtask

    task automatic run0(input int mode, input int err, input int fv, input int fi,
                        input int ps, input bit poke);
        run_t r;
        mode0 = mode;
        for (int i = 0; i < 4; i++) op0_q.push_back('{idx: 2'(i), ops: vec_tbl[i]});
        r.cycles = 8'd12; r.err = 3'(err); r.fv = 1'(fv); r.fi = 2'(fi); r.pass = 1'(ps);
        run0_q.push_back(r);
        @(posedge clock); #1 start0 = 1'b1;
        @(posedge clock); #1 start0 = 1'b0;
        if (poke) begin
            repeat (4) @(posedge clock);
            #1 start0 = 1'b1;
            @(posedge clock); #1 start0 = 1'b0;
        end
        wait_done(0);
    endtask

    task automatic run1(input int mode, input int err, input int fv, input int ps);
        run_t r;
        mode1 = mode;
        op1_q.push_back('{idx: 2'd0, ops: 16'hF101});
        r.cycles = 8'd3; r.err = 3'(err); r.fv = 1'(fv); r.fi = 2'd0; r.pass = 1'(ps);
        run1_q.push_back(r);
        @(posedge clock); #1 start1 = 1'b1;
        @(posedge clock); #1 start1 = 1'b0;
        wait_done(1);
    endtask

    initial begin
        logic found;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_ops0", {a0, b0, c0, d0}, 16'h0);
        chk("reset_status0", {busy0, done0, pass0, err0, idx0, fv0, fidx0}, 12'h0);
        chk("reset_ops1", {a1, b1, c1, d1}, 16'h0);
        chk("reset_status1", {busy1, done1, pass1, err1, idx1, fv1, fidx1}, 7'h0);
        #1 reset = 1'b0;

        run0(0, 0, 0, 0, 1, 1'b0);   // ideal datapath
        run0(1, 4, 1, 0, 0, 1'b1);   // stuck-at-0, plus an ignored mid-run start
        run0(2, 1, 1, 2, 0, 1'b0);   // restart from DONE, vector 2 corrupted
        run0(3, 2, 1, 1, 0, 1'b0);   // vectors 1 and 3 corrupted: first failure captured

        run1(0, 0, 0, 1);
        run1(1, 1, 1, 0);

        // Abort dut0 while vector 2 is being driven.
        mode0 = 3;
        for (int i = 0; i < 4; i++) op0_q.push_back('{idx: 2'(i), ops: vec_tbl[i]});
        @(posedge clock); #1 start0 = 1'b1;
        @(posedge clock); #1 start0 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busy0 && idx0 == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_vector2", found, 1'b1);
        chk("err_before_abort", err0, 3'd1);
        #1 reset = 1'b1;
        op0_q.delete();
        @(posedge clock); #2;
        chk("abort_ops", {a0, b0, c0, d0}, 16'h0);
        chk("abort_status", {busy0, done0, pass0, err0, idx0, fv0, fidx0}, 12'h0);
        @(negedge clock); #1 reset = 1'b0;

        run0(0, 0, 0, 0, 1, 1'b0);   // clean run after abort

        repeat (3) @(posedge clock);
        chk("scoreboard_drained", op0_q.size() + op1_q.size() + run0_q.size() + run1_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
